// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Serialises one DATA_BITS-wide payload per frame onto a UART line:
//   start bit (0), data LSB first, optional parity, STOP_BITS stop bits (1).
//   Bit timing comes from baud_clk. Its rising edges, detected in the clk
//   domain, are the only moments at which tx may change.
//
// Ports
//   clk      in   system clock, all logic on posedge
//   reset    in   asynchronous, active-high reset
//   baud_clk in   bit-rate square wave, synchronous to clk
//   tx_data  in   payload, sampled only at handshake
//   tx_valid in   producer has tx_data available
//   tx_ready out  high only in IDLE; the frame is accepted on tx_valid & tx_ready
//   tx       out  registered serial line, idle high
//   tx_busy  out  high whenever not in IDLE
//   tx_done  out  one-cycle pulse on the tick that closes the last stop bit
//
// Handshake: a transfer happens on any posedge where tx_valid and tx_ready
// are both high. tx_data and tx_valid are ignored in all other cycles.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int MAX_CNT = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 baud_q;
  logic                 tick;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  // One clk-wide pulse per baud_clk rising edge.
  assign tick = baud_clk & ~baud_q;
  assign tx   = tx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_clk;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Every tx change is computed on a tick and registered, so the line moves
  // only on the cycle after a tick and each bit lasts one baud period.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    tx_d     = tx_q;
    tx_ready = 1'b0;
    tx_busy  = 1'b1;
    tx_done  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        tx_busy  = 1'b0;
        tx_d     = 1'b1;
        // A tick in the handshake cycle is ignored: SYNC waits for the next
        // one, which keeps the start bit a full period long.
        if (tx_valid) begin
          shift_d = tx_data;
          par_d   = ^tx_data;
          cnt_d   = '0;
          state_d = SYNC;
        end
      end

      SYNC: begin
        if (tick) begin
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          if (cnt_q == LAST_DATA) begin
            cnt_d = '0;
            if (PAR_EN) begin
              tx_d    = par_q ^ PAR_ODD;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          cnt_d   = '0;
          state_d = STOP;
        end
      end

      STOP: begin
        if (tick) begin
          if (cnt_q == LAST_STOP) begin
            tx_done = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer. Four instances cover 8N1, 8E1, 8O1 and 8N2.
// One instance at a time is exercised (selected by sel). The driver pushes
// each accepted payload into exp_q. The monitor pops it when the start bit
// appears and checks the whole frame cycle by cycle against a frame built
// from the UART framing rules.
module tb_uart_tx_serializer;

  localparam int NCFG     = 4;
  localparam int BAUD_DIV = 8;
  localparam int PEN   [NCFG] = '{0, 1, 1, 0};
  localparam int PODD  [NCFG] = '{0, 0, 1, 0};
  localparam int NSTOP [NCFG] = '{1, 1, 1, 2};

  logic            clk;
  logic            reset;
  logic            baud_clk;
  logic [7:0]      tx_data_a [NCFG];
  logic [NCFG-1:0] tx_valid_v;
  logic [NCFG-1:0] tx_ready_v;
  logic [NCFG-1:0] tx_v;
  logic [NCFG-1:0] busy_v;
  logic [NCFG-1:0] done_v;

  logic [1:0]  sel;
  int          n_cmp;
  int          n_err;
  int          cyc;
  int          hs_count;
  int          frames_done;
  int          mon_k;
  bit          in_frame;
  logic [7:0]  mon_d;
  logic [11:0] frame_bits;
  int          frame_len;
  logic [7:0]  exp_q[$];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    uart_tx_serializer #(
      .DATA_BITS (8),
      .PARITY_EN (PEN[g]),
      .PARITY_ODD(PODD[g]),
      .STOP_BITS (NSTOP[g])
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .baud_clk(baud_clk),
      .tx_data (tx_data_a[g]),
      .tx_valid(tx_valid_v[g]),
      .tx_ready(tx_ready_v[g]),
      .tx      (tx_v[g]),
      .tx_busy (busy_v[g]),
      .tx_done (done_v[g])
    );
  end

  // ---------------- clock / reset / baud ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // baud_clk: period BAUD_DIV clk cycles, changes 1 time unit after posedge.
  initial begin
    baud_clk = 1'b0;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      baud_clk = ((cyc % BAUD_DIV) >= (BAUD_DIV / 2));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference frame ----------------
  // Line bits in time order: start 0, data LSB first, optional parity, stop 1s.
  function automatic void build_frame(input logic [7:0] d, input logic [1:0] c,
                                      output logic [11:0] bits, output int n);
    bits = {4'b1111, d, 1'b0};
    n = 1 + 8 + NSTOP[c];
    if (PEN[c] != 0) begin
      bits[9] = (($countones(d) % 2) == 1) ^ (PODD[c] != 0);
      n = n + 1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cfg %0d, t=%0t)", name, act, req, sel, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame) begin
        if (tx_v[sel] == 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("start_without_handshake", exp_q.size(), 1);
          end else begin
            mon_d = exp_q.pop_front();
            build_frame(mon_d, sel, frame_bits, frame_len);
            in_frame = 1'b1;
            mon_k = 0;
          end
        end else begin
          chk("idle_done", int'(done_v[sel]), 0);
        end
      end
      if (in_frame) begin
        if (mon_k < frame_len * BAUD_DIV) begin
          chk("tx_bit", int'(tx_v[sel]), int'(frame_bits[4'(mon_k / BAUD_DIV)]));
          chk("busy_in_frame", int'(busy_v[sel]), 1);
          chk("ready_in_frame", int'(tx_ready_v[sel]), 0);
          chk("done_position", int'(done_v[sel]), int'(mon_k == frame_len * BAUD_DIV - 1));
          mon_k++;
        end else begin
          chk("ready_after_frame", int'(tx_ready_v[sel]), 1);
          chk("busy_after_frame", int'(busy_v[sel]), 0);
          chk("done_after_frame", int'(done_v[sel]), 0);
          in_frame = 1'b0;
          frames_done++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] d, input bit hold);
    bit hs;
    int t;
    tx_data_a[sel] = d;
    tx_valid_v[sel] = 1'b1;
    hs = 1'b0;
    for (t = 0; t < 400 && !hs; t++) begin
      @(negedge clk);
      hs = tx_ready_v[sel] && !reset;
      @(posedge clk);
    end
    if (!hs) begin
      n_cmp++;
      n_err++;
      $display("FAIL handshake_timeout: no tx_ready within 400 cycles (cfg %0d)", sel);
    end else begin
      exp_q.push_back(d);
      hs_count++;
    end
    #1;
    if (!hold) tx_valid_v[sel] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_frame && tx_ready_v[sel]) break;
    end
    if (t == 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: frame did not complete within 3000 cycles (cfg %0d)", sel);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f0;
    int n;
    reset = 1'b1;
    tx_valid_v = '0;
    for (int c = 0; c < NCFG; c++) tx_data_a[c] = 8'h00;
    sel = 2'd0;
    n_cmp = 0;
    n_err = 0;
    hs_count = 0;
    frames_done = 0;
    mon_k = 0;
    in_frame = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state of every instance.
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      sel = 2'(c);
      chk("reset_tx", int'(tx_v[sel]), 1);
      chk("reset_ready", int'(tx_ready_v[sel]), 1);
      chk("reset_busy", int'(busy_v[sel]), 0);
      chk("reset_done", int'(done_v[sel]), 0);
    end
    sel = 2'd0;
    @(posedge clk);
    #1;

    // Directed frame plus random frames on every configuration.
    for (int c = 0; c < NCFG; c++) begin
      sel = 2'(c);
      send((c == 3) ? 8'h00 : 8'hA5, 1'b0);
      wait_idle();
      for (int r = 0; r < 4; r++) begin
        idle_cycles(int'($urandom_range(0, 12)));
        send(8'($urandom_range(0, 255)), 1'b0);
        wait_idle();
      end
    end

    // tx_valid held high across two frames: exactly two frames leave the line.
    sel = 2'd0;
    f0 = frames_done;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    wait_idle();
    idle_cycles(20);
    chk("held_valid_frames", frames_done - f0, 2);
    chk("held_valid_queue", exp_q.size(), 0);

    // Handshake in the same cycle as a tick: the start bit must wait for the
    // following tick, a full baud period later.
    @(posedge baud_clk);
    #1;
    tx_data_a[sel] = 8'h5A;
    tx_valid_v[sel] = 1'b1;
    @(negedge clk);
    chk("sync_ready", int'(tx_ready_v[sel]), 1);
    @(posedge clk);
    exp_q.push_back(8'h5A);
    hs_count++;
    #1;
    tx_valid_v[sel] = 1'b0;
    n = 0;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (tx_v[sel] == 1'b0) begin
        n = t;
        break;
      end
    end
    chk("sync_hold_cycles", n, BAUD_DIV + 1);
    wait_idle();

    // Reset during data bit 3, then a clean frame.
    send(8'h00, 1'b0);
    n = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_frame && mon_k >= 34 && mon_k <= 36) begin
        n = 1;
        break;
      end
    end
    chk("reach_data_bit3", n, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midframe_reset_tx", int'(tx_v[sel]), 1);
    chk("midframe_reset_done", int'(done_v[sel]), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", int'(tx_ready_v[sel]), 1);
    chk("post_reset_busy", int'(busy_v[sel]), 0);
    chk("post_reset_tx", int'(tx_v[sel]), 1);
    @(posedge clk);
    #1;
    send(8'h3C, 1'b0);
    wait_idle();
    idle_cycles(10);

    // One handshake was aborted by reset; every other one completed once.
    chk("frame_count", frames_done, hs_count - 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, payload bits per frame (legal 5..8).
REQ-002 SHALL have parameter PARITY_EN, default 0, 1 = insert parity bit after data.
REQ-003 SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bit periods per frame (legal 1 or 2).
REQ-005 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port baud_clk  input  1  bit-rate square wave from the baud generator, synchronous to clk; one period = one bit time.
REQ-008 SHALL have port tx_data  input  DATA_BITS  payload byte, sampled only at handshake.
REQ-009 SHALL have port tx_valid  input  1  producer has tx_data available.
REQ-010 SHALL have port tx_ready  output  1  block can accept a frame this cycle.
REQ-011 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-012 SHALL have port tx_busy  output  1  high while a frame is pending or on the line.
REQ-013 SHALL have port tx_done  output  1  single-cycle pulse at frame completion.

Function
REQ-014 SHALL register baud_clk into baud_q every clk; tick = baud_clk & ~baud_q, one clk cycle wide per baud_clk rising edge.
REQ-015 SHALL implement FSM states IDLE, SYNC, START, DATA, PARITY, STOP.
REQ-016 SHALL drive tx_ready = 1 only in IDLE; tx_busy = 1 in every state except IDLE.
REQ-017 SHALL on tx_valid & tx_ready latch tx_data into a shift register and move IDLE -> SYNC; a tick in the same cycle is ignored.
REQ-018 SHALL hold tx = 1 in SYNC and move SYNC -> START on the next tick, driving tx = 0 from the cycle after that tick.
REQ-019 SHALL on each tick in START move to DATA and drive data bit 0; on each tick in DATA drive the next bit, LSB first.
REQ-020 SHALL after DATA_BITS data bit periods move to PARITY if PARITY_EN=1 (tx = XOR of data bits, inverted when PARITY_ODD=1), else to STOP.
REQ-021 SHALL drive tx = 1 in STOP for STOP_BITS bit periods, then on the closing tick move to IDLE and pulse tx_done for exactly that one cycle.
REQ-022 SHALL change tx only on the cycle following a tick (plus reset), so every bit lasts exactly one baud_clk period.
REQ-023 SHALL ignore tx_data and tx_valid changes while not in IDLE; no frame is lost or duplicated.
REQ-024 SHALL accept a following frame no earlier than the cycle after returning to IDLE (tx_ready high one cycle after tx_done).
REQ-025 SHALL use a bit counter wide enough for DATA_BITS and STOP_BITS; counter resets to 0 on every state entry.
REQ-026 SHALL make the frame length from start-bit falling edge to IDLE equal to 1 + DATA_BITS + PARITY_EN + STOP_BITS bit periods.

Reset
REQ-027 SHALL on reset asynchronously force state IDLE, tx = 1, tx_done = 0, baud_q = 0, shift register and counter = 0.
REQ-028 SHALL after reset show tx_ready = 1, tx_busy = 0.
REQ-029 SHALL abort any frame in progress on reset mid-frame with tx returning high immediately and no tx_done.

Verification
REQ-030 SHALL verify 8N1, baud_clk period 8 clk, send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 8 clk, one tx_done, 10 bit periods total.
REQ-031 SHALL verify PARITY_EN=1: 0xA5 even -> parity bit 0; PARITY_ODD=1 -> parity bit 1; 11 bit periods.
REQ-032 SHALL verify STOP_BITS=2 with 0x00 -> 9 low bit periods, then tx high 2 bit periods before tx_done.
REQ-033 SHALL verify tx_valid held high continuously with 0x00 then 0xFF -> two complete frames, exactly two handshakes, tx_ready low while busy.
REQ-034 SHALL verify reset asserted during data bit 3 -> tx = 1 same cycle, tx_ready = 1 after release, no tx_done; next frame 0x3C transmits correctly.
REQ-035 SHALL verify handshake coincident with a tick -> SYNC is held until the following tick, no shortened start bit.
